// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// config_loader: serialises valid/ready bitstream words LSB-first onto a
// configuration scan chain. Optional readback CRC: CONFIG_LOADER_READBACK_EN.
// Revision: 1.0
// ============================================================================
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 12,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  chain_scan_in,
  output logic                  chain_scan_en,
  input  logic                  chain_scan_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int WB = $clog2(WORD_WIDTH + 1);
  localparam logic [WB-1:0]        C_WORD_LAST  = WB'(WORD_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] C_TOTAL_LAST = CNT_WIDTH'(CHAIN_LENGTH - 1);

`ifdef CONFIG_LOADER_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_DONE   = 3'd3,
    S_VERIFY = 3'd4
  } state_t;

  // Serial CRC-8, polynomial x^8+x^2+x+1
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ ({8{fb}} & 8'h07);
  endfunction

  logic [7:0] crc_tx_q, crc_tx_d;
  logic [7:0] crc_rx_q, crc_rx_d;
  logic       error_q, error_d;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  logic unused_scan_out;
  assign unused_scan_out = chain_scan_out;
`endif

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic [WB-1:0]         wbit_q, wbit_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      wbit_q   <= '0;
      total_q  <= '0;
`ifdef CONFIG_LOADER_READBACK_EN
      crc_tx_q <= '0;
      crc_rx_q <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wbit_q   <= wbit_d;
      total_q  <= total_d;
`ifdef CONFIG_LOADER_READBACK_EN
      crc_tx_q <= crc_tx_d;
      crc_rx_q <= crc_rx_d;
      error_q  <= error_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    wbit_d        = wbit_q;
    total_d       = total_q;
    data_ready    = 1'b0;
    chain_scan_en = 1'b0;
    chain_scan_in = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
`ifdef CONFIG_LOADER_READBACK_EN
    crc_tx_d      = crc_tx_q;
    crc_rx_d      = crc_rx_q;
    error_d       = error_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d  = S_LOAD;
          total_d  = '0;
`ifdef CONFIG_LOADER_READBACK_EN
          crc_tx_d = '0;
          crc_rx_d = '0;
          error_d  = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        busy       = 1'b1;
        data_ready = 1'b1;
        if (data_valid) begin
          hold_d  = data_in;
          wbit_d  = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy          = 1'b1;
        chain_scan_en = 1'b1;
        chain_scan_in = hold_q[0];
        hold_d        = hold_q >> 1;
        wbit_d        = wbit_q + 1'b1;
        total_d       = total_q + 1'b1;
`ifdef CONFIG_LOADER_READBACK_EN
        crc_tx_d      = crc8_step(crc_tx_q, hold_q[0]);
`endif
        // Chain-length exit has priority so a partial final word is truncated
        if (total_q == C_TOTAL_LAST) begin
`ifdef CONFIG_LOADER_READBACK_EN
          state_d = S_VERIFY;
          total_d = '0;
`else
          state_d = S_DONE;
`endif
        end else if (wbit_q == C_WORD_LAST) begin
          state_d = S_LOAD;
        end
      end

`ifdef CONFIG_LOADER_READBACK_EN
      S_VERIFY: begin
        busy          = 1'b1;
        chain_scan_en = 1'b1;
        chain_scan_in = chain_scan_out;
        crc_rx_d      = crc8_step(crc_rx_q, chain_scan_out);
        total_d       = total_q + 1'b1;
        if (total_q == C_TOTAL_LAST) begin
          state_d = S_DONE;
          error_d = (crc_rx_d != crc_tx_q);
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

`ifdef CONFIG_LOADER_READBACK_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// tb_config_loader: scoreboard bench with a behavioural 12-bit chain model.
// Revision: 1.0
// ============================================================================
module tb_config_loader;

  localparam int WW = 8;
  localparam int CL = 12;
`ifdef CONFIG_LOADER_READBACK_EN
  localparam int EXP_EN = 2 * CL;
`else
  localparam int EXP_EN = CL;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          chain_scan_in;
  logic          chain_scan_en;
  logic          chain_scan_out;
  logic          busy;
  logic          done;
  logic          error;

  config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .chain_scan_in  (chain_scan_in),
    .chain_scan_en  (chain_scan_en),
    .chain_scan_out (chain_scan_out),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Behavioural chain: first bit shifted ends up at chain[CL-1]
  logic [CL-1:0] chain = '0;
  logic          stuck5 = 1'b0;
  assign chain_scan_out = chain[CL-1];

  always @(posedge clk) begin
    logic [CL-1:0] t;
    t = chain;
    if (chain_scan_en) t = {chain[CL-2:0], chain_scan_in};
    if (stuck5) t[5] = 1'b0;
    chain <= t;
  end

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int en_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected scan bits whenever the DUT shifts
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_cnt = 0;
      end else begin
        if (start && !busy) en_cnt = 0;
        if (chain_scan_en) begin
          if (en_cnt < CL) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL scan_bit_unexpected: got bit %0b with empty queue", chain_scan_in);
            end else begin
              e = exp_q.pop_front();
              chk("scan_bit", chain_scan_in, e);
            end
          end else begin
            chk("recirculate", chain_scan_in, chain_scan_out);
          end
          en_cnt++;
        end else begin
          chk("scan_in_low_when_idle", chain_scan_in, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("ready_wait", ok, 1);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap, input bit mid_start);
    wait_ready();
    for (int g = 0; g < gap; g++) begin
      data_valid = 1'b0;
      chk("gap_ready", data_ready, 1);
      chk("gap_scan_en", chain_scan_en, 0);
      tick();
    end
    data_valid = 1'b1;
    data_in    = w;
    tick();
    data_valid = 1'b0;
    if (mid_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ignored_busy", busy, 1);
    end
  endtask

  task automatic do_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input int gap,
                         input bit mid_start, input logic [CL-1:0] exp_chain,
                         input bit check_chain, input bit exp_err);
    bit got_done;
    for (int i = 0; i < CL; i++) exp_q.push_back(i < WW ? w0[i] : w1[i-WW]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_done_low", done, 0);
    send_word(w0, 0, mid_start);
    send_word(w1, gap, 1'b0);
    got_done = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      tick();
    end
    chk("done_reached", got_done, 1);
    chk("done_busy_low", busy, 0);
    chk("scan_en_count", en_cnt, EXP_EN);
    chk("queue_drained", exp_q.size(), 0);
    if (check_chain) chk("chain_contents", chain, exp_chain);
    chk("error_flag", error, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    tick();
    tick();
    chk("rst_data_ready", data_ready, 0);
    chk("rst_scan_in", chain_scan_in, 0);
    chk("rst_scan_en", chain_scan_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_no_scan_en", en_cnt, 0);
    chk("idle_busy", busy, 0);

    // Basic load: A5,3C -> 1,0,1,0,0,1,0,1,0,0,1,1
    do_load(8'hA5, 8'h3C, 0, 1'b0, 12'hA53, 1'b1, 1'b0);

    // Data gap of 5 cycles before second word
    do_load(8'hA5, 8'h3C, 5, 1'b0, 12'hA53, 1'b1, 1'b0);

    // Reset on the third shift cycle
    for (int i = 0; i < CL; i++) exp_q.push_back(i < WW ? 1'((8'hA5 >> i) & 1) : 1'((8'h3C >> (i - WW)) & 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready();
    data_valid = 1'b1;
    data_in    = 8'hA5;
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_scan_en", chain_scan_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    tick();
    chk("midrst_stays_idle", chain_scan_en, 0);
    do_load(8'hA5, 8'h3C, 0, 1'b0, 12'hA53, 1'b1, 1'b0);

    // Start during SHIFT is ignored; then reload from DONE with all ones
    do_load(8'hA5, 8'h3C, 0, 1'b1, 12'hA53, 1'b1, 1'b0);
    do_load(8'hFF, 8'h0F, 0, 1'b0, 12'hFFF, 1'b1, 1'b0);

`ifdef CONFIG_LOADER_READBACK_EN
    // Bit 5 stuck-at-0 must be caught by the readback CRC
    stuck5 = 1'b1;
    do_load(8'hFF, 8'h0F, 0, 1'b0, 12'hFFF, 1'b0, 1'b1);
    stuck5 = 1'b0;
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/config_loader.md
Name: config_loader

Overview:
- Upstream driver of the configuration scan chain formed by connection blocks, switch blocks and logic tiles. Each of those stages exposes clk/scan_in/scan_out/scan_en, and they are daisy-chained.
- The block accepts bitstream words over a valid/ready interface and serialises them onto the chain's scan_in, one bit per clock.
- It asserts scan_en for exactly CHAIN_LENGTH shift cycles, then reports completion.

Parameters:
- WORD_WIDTH, 8, width of each incoming bitstream word.
- CHAIN_LENGTH, 12, total configuration bits in the attached chain (e.g. 3 connection blocks x 4 bits).
- CNT_WIDTH, 16, width of the total-bit counter; must satisfy 2^CNT_WIDTH > CHAIN_LENGTH.

Ports:
- clk  input  1  single clock; every register samples on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE or DONE.
- data_in  input  WORD_WIDTH  bitstream word.
- data_valid  input  1  data_in valid.
- data_ready  output  1  loader can accept a word this cycle.
- chain_scan_in  output  1  serial bit to scan_in of the first chain element.
- chain_scan_en  output  1  scan_en broadcast to every chain element.
- chain_scan_out  input  1  scan_out of the last chain element (used only with the optional feature).
- busy  output  1  high in LOAD, SHIFT and VERIFY.
- done  output  1  high in DONE.
- error  output  1  readback mismatch flag (optional feature).

Behaviour:
- Reset: state=IDLE. data_ready, chain_scan_in, chain_scan_en, busy, done and error are all 0. Bit counters are cleared. rst takes effect at the next edge from any state, including mid-SHIFT; no further chain_scan_en pulses follow.
- State IDLE: outputs idle. start=1 -> LOAD; total counter cleared; error cleared.
- State LOAD: data_ready=1, chain_scan_en=0.
  - A word is accepted on data_valid & data_ready; it is captured into a shift holding register and the word-bit counter is cleared.
  - Next state is SHIFT. data_valid without ready is ignored.
- State SHIFT: data_ready=0, chain_scan_en=1, chain_scan_in=holding[0].
  - Each cycle: holding shifts right; word-bit and total counters increment.
  - Bit order: LSB first; words are shifted in arrival order.
  - Exit when the total counter reaches CHAIN_LENGTH: go to DONE, or VERIFY with the feature.
  - Otherwise, exit when the word-bit counter reaches WORD_WIDTH: go to LOAD.
  - The final word may be partial: only the remaining bits are shifted and its unused upper bits are discarded.
- Latency: word accepted at edge N -> first chain_scan_en=1 cycle begins after edge N. Throughput is WORD_WIDTH+1 cycles per full word.
- chain_scan_en is low during every LOAD cycle, so chain elements hold their contents across data gaps. Total scan_en-high cycles per load = CHAIN_LENGTH exactly.
- State DONE: done=1 (level), busy=0. start=1 -> LOAD (reload; total counter cleared, done drops next cycle).
- start while busy is ignored. start and data_valid in the same IDLE cycle: only start is acted on.
- chain_scan_in is 0 whenever chain_scan_en=0.

Optional Feature:
- Macro: CONFIG_LOADER_READBACK_EN.
- Defined:
  - During SHIFT, an 8-bit CRC (poly x^8+x^2+x+1, init 0x00) is updated over every shifted bit.
  - After the last bit, the loader enters VERIFY for CHAIN_LENGTH cycles with chain_scan_en=1 and chain_scan_in=chain_scan_out (recirculate). This restores the chain to its loaded contents.
  - A second CRC is computed over chain_scan_out in the same order.
  - On exit to DONE, error=1 if the two CRCs differ. error is held until the next start or rst.
  - Total scan_en-high cycles per load = 2*CHAIN_LENGTH.
- Not defined: no VERIFY state or CRC logic; error tied 0; chain_scan_out unused.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0. start=0 for 10 cycles -> chain_scan_en never 1.
- Basic load, CHAIN_LENGTH=12: start, then words 0xA5, 0x3C -> chain_scan_in at scan_en cycles = 1,0,1,0,0,1,0,1,0,0,1,1. Exactly 12 scan_en cycles. done=1; a 12-bit behavioural chain model holds the expected pattern.
- Data gap: hold data_valid=0 for 5 cycles between words -> scan_en=0 throughout the gap. Chain contents identical to the previous scenario; data_ready=1 during the gap.
- Reset mid-SHIFT: assert rst on the 3rd shift cycle -> next cycle state IDLE, chain_scan_en=0, busy=0, done=0. A subsequent full load completes with 12 scan_en cycles.
- Reload and ignored start: pulse start during SHIFT -> no effect. start in DONE with words 0xFF, 0x0F -> 12 ones shifted, done re-asserts.
- Readback (macro defined): correct chain model -> error=0 and 24 scan_en cycles. Chain model with bit 5 stuck-at-0 and pattern 0xFF, 0x0F -> error=1 in DONE.
